spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//  SPI responder (slave) with a bus-slave register port for the CPU, companion to the SPI master.
//  Oversamples sclk/ss_n/mosi in the clk_i domain, shifts MSB first, supports all four CPOL/CPHA modes.
//  Single-byte TX holding register, single-byte RX register, status flags, level irq.
//  Sits on the system bus alongside the other I/O blocks; the pads connect to an external SPI master.
// PARAMETERS
//  SYNC_STAGES  2   flops in each input synchronizer for sclk, ss_n and mosi (min 2)
//  IDLE_BYTE    8'hFF  byte shifted out when the TX holding register is empty
// PORTS
//  clk_i    in   1   system clock; sclk must be <= clk_i/8
//  rst_i    in   1   synchronous, active-high reset
//  cyc_i    in   1   bus cycle
//  stb_i    in   1   bus strobe
//  we_i     in   1   1=write, 0=read
//  adr_i    in   1   register select (0=data, 1=ctrl/status)
//  sel_i    in   4   byte lanes
//  dat_i    in   32  write data
//  dat_o    out  32  read data, registered
//  ack_o    out  1   one-cycle bus acknowledge
//  sclk     in   1   SPI clock from external master (async)
//  ss_n     in   1   slave select, active low (async)
//  mosi     in   1   serial data in (async)
//  miso     out  1   serial data out
//  miso_oe  out  1   miso drive enable (pad tristates when 0)
//  irq      out  1   high while rx_unread or overrun
// BEHAVIOUR
//  Reset: dat_o=0, ack_o=0, miso=1, miso_oe=0, irq=0, conf=0, rx_byte=0, all flags 0, bitcnt=0, FSM=IDLE.
//  Bus FSM IDLE/DONE: a cycle with cyc_i&stb_i in IDLE acts in that cycle and moves to DONE. ack_o=1 in DONE only. DONE returns to IDLE.
//   adr0 write: tx_hold<=dat_i[7:0], tx_full<=1. A write while full overwrites and still acks.
//   adr0 read: dat_o<={24'h0,rx_byte}, rx_unread<=0.
//   adr1 write: sel_i[2] -> conf<=dat_i[17:16] ({cpol,cpha}). sel_i[0]&dat_i[2] clears overrun.
//   adr1 read: dat_o<={14'h0,conf,12'h0,ss_act,overrun,tx_full,rx_unread}.
//  Sync: each async input passes SYNC_STAGES flops. Edges are detected from the last stage and its delayed copy.
//  SPI FSM IDLE/ACTIVE:
//   IDLE->ACTIVE on synced ss_n falling. Latch conf as mode for the whole select window.
//    Load shifter from tx_hold if tx_full (tx_full<=0), else IDLE_BYTE. bitcnt<=0.
//    miso_oe<=1, miso<=shifter[7].
//   ACTIVE->IDLE on synced ss_n high: partial byte discarded, bitcnt<=0, miso_oe<=0, miso<=1.
//  Leading edge = rising if cpol=0, falling if cpol=1; the trailing edge is the opposite.
//   cpha=0: sample mosi on leading; shift on trailing (miso<=next bit).
//   cpha=1: shift on leading, except the first leading edge of a byte; sample on trailing.
//  Byte complete on the 8th sample edge:
//   rx_byte<=assembled byte; overrun<=1 if rx_unread already set (rx_byte still overwritten); rx_unread<=1.
//   Shifter reloads from tx_hold/IDLE_BYTE (same rule as select) and bitcnt<=0.
//   For cpha=0, miso<=new bit7 in that same cycle.
//  Simultaneous events:
//   byte-complete and adr0 read in one cycle: dat_o gets the old rx_byte; rx_unread ends 1.
//   shifter reload and adr0 write in one cycle: the shifter takes the old tx_hold; the new byte stays queued (tx_full=1).
//   overrun-clear and a new overrun in one cycle: overrun ends 1.
//  conf writes during ACTIVE take effect at the next ss_n assertion.
//  ss_act = synced ~ss_n. irq = rx_unread|overrun (registered).
//  rst_i mid-transfer: everything returns to reset values at once. The transfer resumes only on a new ss_n falling edge.
// TESTING
//  1 Mode 0, tx_hold=8'hA5, master sends 8'h3C -> miso bits 1,0,1,0,0,1,0,1; rx_byte=8'h3C; rx_unread=1; irq=1; tx_full=0.
//  2 Modes 1,2,3 each: master sends 8'h81, slave sends 8'h7E -> both sides receive the other byte exactly.
//  3 No TX write, 2-byte burst 8'h11,8'h22 without an rx read -> miso=FF,FF; rx_byte=8'h22; overrun=1; status read=...0xF (ss_act=1).
//  4 ss_n deasserted after 5 bits of 8'hF0, then full byte 8'h0F -> rx_byte=8'h0F; rx_unread set only once.
//  5 adr0 read issued on the byte-complete cycle -> dat_o=previous byte, rx_unread still 1; next read returns the new byte.
//  6 rst_i pulsed mid-byte -> miso_oe=0, flags 0 next cycle; next select window with tx_hold=8'hC3 -> miso sends C3.

Source files
------------

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI responder with bus register port, four CPOL/CPHA modes
module spi_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic        adr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    input  logic        sclk,
    input  logic        ss_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic        irq
);

    localparam logic [0:0] BUS_IDLE   = 1'b0;
    localparam logic [0:0] BUS_DONE   = 1'b1;
    localparam logic [0:0] SPI_IDLE   = 1'b0;
    localparam logic [0:0] SPI_ACTIVE = 1'b1;

    // synchronizers and edge-detect history
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_dly_q;
    logic                   ss_dly_q;
    logic [SYNC_STAGES:0]   prime_q;

    // bus side state
    logic [0:0]  bus_state_q, bus_state_d;
    logic [31:0] dat_q, dat_d;
    logic [1:0]  conf_q, conf_d;
    logic [7:0]  tx_hold_q, tx_hold_d;
    logic        tx_full_q, tx_full_d;
    logic        rx_unread_q, rx_unread_d;
    logic        overrun_q, overrun_d;
    logic        irq_q, irq_d;

    // SPI side state
    logic [0:0]  spi_state_q, spi_state_d;
    logic [1:0]  mode_q, mode_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        miso_q, miso_d;
    logic        miso_oe_q, miso_oe_d;

    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_fall;
    logic lead_edge, trail_edge, sample_edge, drive_edge;
    logic reload, byte_done;
    logic [7:0] reload_byte;
    logic bus_go, wr0, rd0, wr1, rd1;
    logic [31:0] status;

    // Input synchronizers. ss_n chain resets to deasserted; prime_q marks when the
    // whole chain plus the delayed copy hold real pad samples, so a select already
    // low across reset is not mistaken for a new falling edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            ss_dly_q    <= 1'b1;
            prime_q     <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
            ss_dly_q    <= ss_sync_q[SYNC_STAGES-1];
            prime_q     <= {prime_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign ss_fall   = prime_q[SYNC_STAGES] & ss_dly_q & ~ss_s;

    // mode_q = {cpol, cpha} latched for the select window
    assign lead_edge   = mode_q[1] ? sclk_fall : sclk_rise;
    assign trail_edge  = mode_q[1] ? sclk_rise : sclk_fall;
    assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
    assign drive_edge  = mode_q[0] ? lead_edge : trail_edge;
    assign reload_byte = tx_full_q ? tx_hold_q : IDLE_BYTE;

    // SPI shift engine: select handling, sampling, driving, byte completion
    always_comb begin
        spi_state_d = spi_state_q;
        mode_d      = mode_q;
        shift_d     = shift_q;
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        bitcnt_d    = bitcnt_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        reload      = 1'b0;
        byte_done   = 1'b0;
        case (spi_state_q)
            SPI_IDLE: begin
                if (ss_fall) begin
                    spi_state_d = SPI_ACTIVE;
                    mode_d      = conf_q;
                    reload      = 1'b1;
                    shift_d     = reload_byte;
                    rx_shift_d  = 8'h00;
                    bitcnt_d    = 3'd0;
                    miso_oe_d   = 1'b1;
                    miso_d      = reload_byte[7];
                end
            end
            SPI_ACTIVE: begin
                if (ss_s) begin
                    // deselect drops any partial byte
                    spi_state_d = SPI_IDLE;
                    bitcnt_d    = 3'd0;
                    miso_oe_d   = 1'b0;
                    miso_d      = 1'b1;
                end else begin
                    if (sample_edge) begin
                        if (bitcnt_q == 3'd7) begin
                            byte_done = 1'b1;
                            rx_byte_d = {rx_shift_q[6:0], mosi_s};
                            reload    = 1'b1;
                            shift_d   = reload_byte;
                            bitcnt_d  = 3'd0;
                            if (!mode_q[0]) begin
                                miso_d = reload_byte[7];
                            end
                        end else begin
                            rx_shift_d = {rx_shift_q[6:0], mosi_s};
                            bitcnt_d   = bitcnt_q + 3'd1;
                        end
                    end
                    // A drive edge before any sample of the byte only presents bit7;
                    // this skips the first leading edge for cpha=1 and the trailing
                    // edge that follows a reload for cpha=0.
                    if (drive_edge) begin
                        if (bitcnt_q == 3'd0) begin
                            miso_d = shift_q[7];
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            miso_d  = shift_q[6];
                        end
                    end
                end
            end
            default: spi_state_d = SPI_IDLE;
        endcase
    end

    assign bus_go = (bus_state_q == BUS_IDLE) & cyc_i & stb_i;
    assign wr0    = bus_go & we_i & ~adr_i;
    assign rd0    = bus_go & ~we_i & ~adr_i;
    assign wr1    = bus_go & we_i & adr_i;
    assign rd1    = bus_go & ~we_i & adr_i;
    assign status = {14'h0, conf_q, 12'h0, ~ss_s, overrun_q, tx_full_q, rx_unread_q};

    // Bus handshake and register/flag updates; SPI events win over bus clears
    always_comb begin
        bus_state_d = BUS_IDLE;
        dat_d       = dat_q;
        conf_d      = conf_q;
        tx_hold_d   = tx_hold_q;
        tx_full_d   = tx_full_q;
        rx_unread_d = rx_unread_q;
        overrun_d   = overrun_q;
        if (bus_go) begin
            bus_state_d = BUS_DONE;
        end
        if (rd0) begin
            dat_d = {24'h0, rx_byte_q};
        end
        if (rd1) begin
            dat_d = status;
        end
        if (wr1 && sel_i[2]) begin
            conf_d = dat_i[17:16];
        end
        if (wr0) begin
            tx_hold_d = dat_i[7:0];
        end
        // reload consumes the old hold value; a same-cycle write stays queued
        if (reload) begin
            tx_full_d = 1'b0;
        end
        if (wr0) begin
            tx_full_d = 1'b1;
        end
        if (rd0) begin
            rx_unread_d = 1'b0;
        end
        if (byte_done) begin
            rx_unread_d = 1'b1;
        end
        if (wr1 && sel_i[0] && dat_i[2]) begin
            overrun_d = 1'b0;
        end
        if (byte_done && rx_unread_q) begin
            overrun_d = 1'b1;
        end
        irq_d = rx_unread_d | overrun_d;
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus_state_q <= BUS_IDLE;
            dat_q       <= 32'h0;
            conf_q      <= 2'b00;
            tx_hold_q   <= 8'h00;
            tx_full_q   <= 1'b0;
            rx_unread_q <= 1'b0;
            overrun_q   <= 1'b0;
            irq_q       <= 1'b0;
            spi_state_q <= SPI_IDLE;
            mode_q      <= 2'b00;
            shift_q     <= 8'h00;
            rx_shift_q  <= 8'h00;
            rx_byte_q   <= 8'h00;
            bitcnt_q    <= 3'd0;
            miso_q      <= 1'b1;
            miso_oe_q   <= 1'b0;
        end else begin
            bus_state_q <= bus_state_d;
            dat_q       <= dat_d;
            conf_q      <= conf_d;
            tx_hold_q   <= tx_hold_d;
            tx_full_q   <= tx_full_d;
            rx_unread_q <= rx_unread_d;
            overrun_q   <= overrun_d;
            irq_q       <= irq_d;
            spi_state_q <= spi_state_d;
            mode_q      <= mode_d;
            shift_q     <= shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            bitcnt_q    <= bitcnt_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
        end
    end

    assign dat_o   = dat_q;
    assign ack_o   = (bus_state_q == BUS_DONE);
    assign miso    = miso_q;
    assign miso_oe = miso_oe_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - scoreboard bench for spi_slave with bit-banged SPI master
module tb_spi_slave;
    localparam int SYNC = 2;
    localparam int H    = 8;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we, adr;
    logic [3:0]  sel;
    logic [31:0] dat_i, dat_o;
    logic        ack, sclk, ss_n, mosi, miso, miso_oe, irq;

    always #5 clk = ~clk;

    spi_slave #(.SYNC_STAGES(SYNC), .IDLE_BYTE(8'hFF)) dut (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
        .sel_i(sel), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack),
        .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .irq(irq)
    );

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [1:0] conf_m, mode_m;
    logic [7:0] tx_hold_m, rx_byte_m, load_m;
    logic       tx_full_m, rx_unread_m, overrun_m, ss_m;

    logic [31:0] exp_rd_q[$];
    string       exp_rd_name[$];
    logic [7:0]  exp_miso_q[$];
    logic [7:0]  got_miso_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    // monitor: pops expected read data on every read acknowledge, and pairs miso bytes
    always @(negedge clk) begin
        if (ack && !we) begin
            if (exp_rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected got=%h required=no_read", dat_o);
            end else begin
                check(exp_rd_name.pop_front(), dat_o, exp_rd_q.pop_front());
            end
        end
        while (got_miso_q.size() > 0 && exp_miso_q.size() > 0) begin
            check("miso_byte", {24'h0, got_miso_q.pop_front()}, {24'h0, exp_miso_q.pop_front()});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] status_m();
        return {14'h0, conf_m, 12'h0, ss_m, overrun_m, tx_full_m, rx_unread_m};
    endfunction

    function automatic logic [7:0] take();
        if (tx_full_m) begin
            tx_full_m = 1'b0;
            return tx_hold_m;
        end
        return 8'hFF;
    endfunction

    task automatic bus(input logic w, input logic a, input logic [3:0] s, input logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
        tick(1);
        cyc = 1'b0; stb = 1'b0;
        tick(1);
    endtask

    task automatic rd_data();
        exp_rd_q.push_back({24'h0, rx_byte_m});
        exp_rd_name.push_back("rd_data");
        rx_unread_m = 1'b0;
        bus(1'b0, 1'b0, 4'hF, 32'h0);
    endtask

    task automatic rd_stat();
        exp_rd_q.push_back(status_m());
        exp_rd_name.push_back("rd_status");
        bus(1'b0, 1'b1, 4'hF, 32'h0);
    endtask

    task automatic wr_tx(input logic [7:0] b);
        bus(1'b1, 1'b0, 4'h1, {24'h0, b});
        tx_hold_m = b;
        tx_full_m = 1'b1;
    endtask

    task automatic wr_conf(input logic [1:0] m);
        bus(1'b1, 1'b1, 4'b0100, {14'h0, m, 16'h0});
        conf_m = m;
    endtask

    task automatic clr_ovr();
        bus(1'b1, 1'b1, 4'b0001, 32'h4);
        overrun_m = 1'b0;
    endtask

    task automatic chk_irq();
        check("irq", {31'h0, irq}, {31'h0, rx_unread_m | overrun_m});
    endtask

    task automatic select();
        mode_m = conf_m;
        sclk = conf_m[1];
        tick(4);
        load_m = take();
        ss_n = 1'b0;
        ss_m = 1'b1;
        tick(2 * H);
    endtask

    task automatic deselect();
        tick(H);
        ss_n = 1'b1;
        ss_m = 1'b0;
        tick(2 * H);
    endtask

    // data read lined up with the cycle the DUT acts on the edge just driven
    task automatic rd_at_edge();
        repeat (SYNC) @(posedge clk);
        #1;
        exp_rd_q.push_back({24'h0, rx_byte_m});
        exp_rd_name.push_back("rd_on_byte_done");
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 1'b0; sel = 4'hF;
        tick(1);
        cyc = 1'b0; stb = 1'b0;
        tick(H - SYNC - 1);
    endtask

    task automatic xfer(input logic [7:0] mo, input int nbits, input bit rd_done, output logic [7:0] mi);
        logic cpol, cpha;
        cpol = mode_m[1];
        cpha = mode_m[0];
        mi = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            int i;
            i = 7 - k;
            if (!cpha) begin
                mosi = mo[i];
                tick(H);
                mi[i] = miso;
                sclk = ~cpol;
                if (k == 7 && rd_done) rd_at_edge(); else tick(H);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = mo[i];
                tick(H);
                mi[i] = miso;
                sclk = cpol;
                if (k == 7 && rd_done) rd_at_edge(); else tick(H);
            end
        end
    endtask

    task automatic spi_byte(input logic [7:0] mo, input bit rd_done);
        logic [7:0] mi;
        logic ur;
        ur = rx_unread_m;
        exp_miso_q.push_back(load_m);
        xfer(mo, 8, rd_done, mi);
        got_miso_q.push_back(mi);
        overrun_m   = overrun_m | ur;
        rx_unread_m = 1'b1;
        rx_byte_m   = mo;
        load_m      = take();
    endtask

    task automatic model_reset();
        conf_m = 2'b00; mode_m = 2'b00; tx_hold_m = 8'h00; rx_byte_m = 8'h00;
        tx_full_m = 1'b0; rx_unread_m = 1'b0; overrun_m = 1'b0; load_m = 8'hFF;
    endtask

    initial begin
        logic [7:0] junk;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 1'b0; sel = 4'h0; dat_i = 32'h0;
        sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0; ss_m = 1'b0;
        model_reset();
        tick(3);
        check("rst_dat_o", dat_o, 32'h0);
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_miso", {31'h0, miso}, 32'h1);
        check("rst_miso_oe", {31'h0, miso_oe}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rst = 1'b0;
        tick(5);
        rd_stat();

        // mode 0, A5 out, 3C in
        wr_tx(8'hA5);
        select();
        spi_byte(8'h3C, 1'b0);
        deselect();
        chk_irq();
        rd_stat();
        rd_data();

        // modes 1..3: 7E out, 81 in
        for (int m = 1; m < 4; m++) begin
            wr_conf(2'(m));
            wr_tx(8'h7E);
            select();
            spi_byte(8'h81, 1'b0);
            deselect();
            rd_data();
        end

        // idle-byte burst with overrun, status seen while selected
        wr_conf(2'b00);
        select();
        spi_byte(8'h11, 1'b0);
        spi_byte(8'h22, 1'b0);
        wr_tx(8'h5C);
        rd_stat();
        deselect();
        chk_irq();
        rd_data();
        clr_ovr();
        rd_stat();

        // partial byte dropped on deselect, then a full byte
        select();
        xfer(8'hF0, 5, 1'b0, junk);
        deselect();
        rd_stat();
        select();
        spi_byte(8'h0F, 1'b0);
        deselect();
        rd_stat();
        rd_data();

        // read landing on the byte-complete cycle
        select();
        spi_byte(8'h5A, 1'b0);
        rd_data();
        spi_byte(8'hC7, 1'b1);
        deselect();
        rd_stat();
        rd_data();

        // reset mid-byte
        wr_tx(8'h99);
        select();
        xfer(8'hAA, 4, 1'b0, junk);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        model_reset();
        check("midrst_miso_oe", {31'h0, miso_oe}, 32'h0);
        check("midrst_miso", {31'h0, miso}, 32'h1);
        check("midrst_irq", {31'h0, irq}, 32'h0);
        sclk = 1'b0;
        tick(10);
        check("midrst_no_reselect", {31'h0, miso_oe}, 32'h0);
        rd_stat();
        ss_n = 1'b1;
        ss_m = 1'b0;
        tick(2 * H);
        wr_tx(8'hC3);
        select();
        spi_byte(8'h3D, 1'b0);
        deselect();
        rd_data();

        // randomized windows
        for (int w = 0; w < 16; w++) begin
            int nb;
            wr_conf(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) wr_tx(8'($urandom));
            select();
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                spi_byte(8'($urandom), $urandom_range(0, 3) == 0);
                if ($urandom_range(0, 3) == 0) wr_tx(8'($urandom));
                if ($urandom_range(0, 3) == 0) wr_conf(2'($urandom_range(0, 3)));
            end
            if ($urandom_range(0, 2) == 0) rd_stat();
            deselect();
            chk_irq();
            rd_stat();
            if ($urandom_range(0, 1) == 1) rd_data();
            if ($urandom_range(0, 2) == 0) clr_ovr();
        end

        tick(5);
        check("rd_queue_drained", exp_rd_q.size(), 32'h0);
        check("miso_queue_drained", exp_miso_q.size() + got_miso_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
